// File: rtl/lib_islip_iteration_scheduler_if.sv
// Handshake bundle between the VOQ status logic / switch datapath and the
// iSLIP scheduler. The statistics ports exist only when
// LIB_ISLIP_SCHED_STATS_EN is defined.
interface lib_islip_iteration_scheduler_if #(
    parameter int N          = 4,
    parameter int M          = 4,
    parameter int ITERATIONS = 3
);
    localparam int CW = $clog2(ITERATIONS + 1);

    logic                i_start;
    logic [0:N-1][0:M-1] i_request;
    logic                o_busy;
    logic                o_valid;
    logic                i_ready;
    logic [0:N-1][0:M-1] o_match;
    logic [CW-1:0]       o_iterations;
`ifdef LIB_ISLIP_SCHED_STATS_EN
    logic [31:0]         o_stat_schedules;
    logic [31:0]         o_stat_matches;

    modport master (
        output i_start, i_request, i_ready,
        input  o_busy, o_valid, o_match, o_iterations, o_stat_schedules, o_stat_matches
    );
    modport slave (
        input  i_start, i_request, i_ready,
        output o_busy, o_valid, o_match, o_iterations, o_stat_schedules, o_stat_matches
    );
`else
    modport master (
        output i_start, i_request, i_ready,
        input  o_busy, o_valid, o_match, o_iterations
    );
    modport slave (
        input  i_start, i_request, i_ready,
        output o_busy, o_valid, o_match, o_iterations
    );
`endif
endinterface

// File: rtl/lib_islip_iteration_scheduler.sv
// Multi-iteration iSLIP scheduler for an NxM crossbar. A request matrix is
// captured on start, then up to ITERATIONS request-grant-accept rounds run,
// one per clock, and the conflict-free matching is offered on valid/ready.
// Optional schedule/match statistics counters: LIB_ISLIP_SCHED_STATS_EN.
module lib_islip_iteration_scheduler #(
    parameter int N          = 4,
    parameter int M          = 4,
    parameter int ITERATIONS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    lib_islip_iteration_scheduler_if.slave    bus
);
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int CW = $clog2(ITERATIONS + 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t              state, state_nxt;
    logic [0:N-1][0:M-1] req_q, match_q, new_match, match_nxt;
    logic [CW-1:0]       round_q, round_nxt;
    logic [NW-1:0]       g_ptr   [M];
    logic [MW-1:0]       a_ptr   [N];
    logic [M-1:0]        gnt_valid;
    logic [NW-1:0]       gnt_idx [M];
    logic [N-1:0]        acc_valid;
    logic [MW-1:0]       acc_idx [N];
    logic [N-1:0]        row_used;
    logic [M-1:0]        col_used;
    logic                any_new, all_rows, all_cols, round_exit;

    // Cyclic (base + off) mod N; off never exceeds N-1.
    function automatic logic [NW-1:0] add_mod_n(input logic [NW-1:0] base, input int off);
        logic [NW:0] sum;
        sum = {1'b0, base} + (NW+1)'(off);
        if (sum >= (NW+1)'(N)) sum = sum - (NW+1)'(N);
        return sum[NW-1:0];
    endfunction

    // Cyclic (base + off) mod M; off never exceeds M-1.
    function automatic logic [MW-1:0] add_mod_m(input logic [MW-1:0] base, input int off);
        logic [MW:0] sum;
        sum = {1'b0, base} + (MW+1)'(off);
        if (sum >= (MW+1)'(M)) sum = sum - (MW+1)'(M);
        return sum[MW-1:0];
    endfunction

    // Inputs and outputs already matched in earlier rounds of this schedule.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        row_used = '0;
        col_used = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                if (match_q[i][j]) begin
                    row_used[i] = 1'b1;
                    col_used[j] = 1'b1;
                end
            end
        end
    end

    // Grant phase: each free output picks the first free requesting input from its pointer.
    always_comb begin
        logic [NW-1:0] cand_i;
        cand_i    = '0;
        gnt_valid = '0;
        for (int j = 0; j < M; j++) begin
            gnt_idx[j] = '0;
            for (int k = 0; k < N; k++) begin
                cand_i = add_mod_n(g_ptr[j], k);
                if (!col_used[j] && !gnt_valid[j] && req_q[cand_i][j] && !row_used[cand_i]) begin
                    gnt_valid[j] = 1'b1;
                    gnt_idx[j]   = cand_i;
                end
            end
        end
    end

    // Accept phase: each free input takes the first granting output from its pointer.
    always_comb begin
        logic [MW-1:0] cand_j;
        cand_j    = '0;
        acc_valid = '0;
        new_match = '0;
        for (int i = 0; i < N; i++) begin
            acc_idx[i] = '0;
            for (int k = 0; k < M; k++) begin
                cand_j = add_mod_m(a_ptr[i], k);
                if (!row_used[i] && !acc_valid[i] && gnt_valid[cand_j] && gnt_idx[cand_j] == NW'(i)) begin
                    acc_valid[i]         = 1'b1;
                    acc_idx[i]           = cand_j;
                    new_match[i][cand_j] = 1'b1;
                end
            end
        end
    end

    // Round result and the exit decision taken at the registering edge.
    always_comb begin
        match_nxt = match_q | new_match;
        round_nxt = round_q + CW'(1);
        any_new   = |new_match;
        all_rows  = 1'b1;
        all_cols  = 1'b1;
        for (int i = 0; i < N; i++) all_rows = all_rows & (|match_nxt[i]);
        for (int j = 0; j < M; j++) begin
            logic col_hit;
            col_hit = 1'b0;
            for (int i = 0; i < N; i++) col_hit = col_hit | match_nxt[i][j];
            all_cols = all_cols & col_hit;
        end
        round_exit = (round_nxt == CW'(ITERATIONS)) || !any_new || all_rows || all_cols;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; start is honoured only in IDLE, ready only in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_start) state_nxt = ITER;
            ITER:    if (round_exit) state_nxt = DONE;
            DONE:    if (bus.i_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, match accumulation and round-1-only pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the pointer arrays are reset explicitly; their start position defines the first schedule.
            req_q   <= '0;
            match_q <= '0;
            round_q <= '0;
            for (int j = 0; j < M; j++) g_ptr[j] <= '0;
            for (int i = 0; i < N; i++) a_ptr[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        req_q   <= bus.i_request;
                        match_q <= '0;
                        round_q <= '0;
                    end
                end
                ITER: begin
                    match_q <= match_nxt;
                    round_q <= round_nxt;
                    if (round_q == '0) begin
                        for (int j = 0; j < M; j++) begin
                            if (gnt_valid[j] && new_match[gnt_idx[j]][j]) g_ptr[j] <= add_mod_n(gnt_idx[j], 1);
                        end
                        for (int i = 0; i < N; i++) begin
                            if (acc_valid[i]) a_ptr[i] <= add_mod_m(acc_idx[i], 1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_busy       = (state != IDLE);
    assign bus.o_valid      = (state == DONE);
    assign bus.o_match      = match_q;
    assign bus.o_iterations = round_q;

`ifdef LIB_ISLIP_SCHED_STATS_EN
    logic [31:0] stat_schedules, stat_matches;
    logic [32:0] match_sum;
    logic        handshake;

    assign handshake = (state == DONE) && bus.i_ready;
    assign match_sum = {1'b0, stat_matches} + 33'($countones(match_q));

    // Saturating counters of delivered schedules and matched pairs.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_schedules <= '0;
            stat_matches   <= '0;
        end else if (handshake) begin
            if (stat_schedules != '1) stat_schedules <= stat_schedules + 32'd1;
            stat_matches <= match_sum[32] ? '1 : match_sum[31:0];
        end
    end

    assign bus.o_stat_schedules = stat_schedules;
    assign bus.o_stat_matches   = stat_matches;
`endif
endmodule

// File: tb/tb_lib_islip_iteration_scheduler.sv
// Self-checking bench for lib_islip_iteration_scheduler: directed cases plus
// randomized schedules compared with a round-by-round iSLIP reference model.
module tb_lib_islip_iteration_scheduler;
    localparam int N     = 4;
    localparam int M     = 4;
    localparam int ITERS = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gp [M];
    int   ap [N];
    int   exp_sched = 0;
    int   exp_matches = 0;

    always #5 clk = ~clk;

    lib_islip_iteration_scheduler_if #(.N(N), .M(M), .ITERATIONS(ITERS)) bus ();
    lib_islip_iteration_scheduler_if #(.N(N), .M(M), .ITERATIONS(4))     bus4 ();

    lib_islip_iteration_scheduler #(.N(N), .M(M), .ITERATIONS(ITERS)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    lib_islip_iteration_scheduler #(.N(N), .M(M), .ITERATIONS(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s did not hold", tag);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < M; j++) gp[j] = 0;
        for (int i = 0; i < N; i++) ap[i] = 0;
        exp_sched   = 0;
        exp_matches = 0;
    endtask

    // Reference iSLIP: rounds over integer match tables, pointers moved in round 1 only.
    task automatic model_run(input logic [0:N-1][0:M-1] req, input int iters,
                             output logic [0:N-1][0:M-1] mt, output int rounds);
        int in_m [N];
        int out_m[M];
        int grant[M];
        int nnew, nin, cand;
        for (int i = 0; i < N; i++) in_m[i] = -1;
        for (int j = 0; j < M; j++) out_m[j] = -1;
        rounds = 0;
        for (int r = 1; r <= iters; r++) begin
            rounds = r;
            for (int j = 0; j < M; j++) begin
                grant[j] = -1;
                if (out_m[j] < 0) begin
                    for (int k = 0; k < N; k++) begin
                        cand = (gp[j] + k) % N;
                        if (grant[j] < 0 && req[cand][j] && in_m[cand] < 0) grant[j] = cand;
                    end
                end
            end
            nnew = 0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < M; k++) begin
                    cand = (ap[i] + k) % M;
                    if (in_m[i] < 0 && grant[cand] == i) begin
                        in_m[i]     = cand;
                        out_m[cand] = i;
                        nnew++;
                        if (r == 1) begin
                            ap[i]    = (cand + 1) % M;
                            gp[cand] = (i + 1) % N;
                        end
                    end
                end
            end
            nin = 0;
            for (int i = 0; i < N; i++) if (in_m[i] >= 0) nin++;
            if (nnew == 0 || nin == N || nin == M) break;
        end
        mt = '0;
        for (int i = 0; i < N; i++) if (in_m[i] >= 0) mt[i][in_m[i]] = 1'b1;
    endtask

    // One full schedule on the default DUT with `hold` stalled cycles in DONE.
    task automatic run_sched(input logic [0:N-1][0:M-1] req, input int hold, input string tag,
                             output logic [0:N-1][0:M-1] obs_m, output int obs_k);
        logic [0:N-1][0:M-1] exp_m;
        int exp_k, cyc;
        model_run(req, ITERS, exp_m, exp_k);
        bus.i_request = req;
        bus.i_start   = 1'b1;
        @(posedge clk); #1;
        bus.i_start   = 1'b0;
        bus.i_request = 16'($urandom);
        check({tag, "/busy"}, 64'(bus.o_busy), 64'(1));
        cyc = 0;
        while (!bus.o_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        obs_m = bus.o_match;
        obs_k = int'(bus.o_iterations);
        check({tag, "/latency"}, 64'(cyc), 64'(exp_k));
        check({tag, "/match"}, 64'(bus.o_match), 64'(exp_m));
        check({tag, "/iters"}, 64'(bus.o_iterations), 64'(exp_k));
        for (int h = 0; h < hold; h++) begin
            bus.i_start   = 1'b1;
            bus.i_request = 16'($urandom);
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, 64'(bus.o_valid), 64'(1));
            check({tag, "/hold_match"}, 64'(bus.o_match), 64'(exp_m));
            check({tag, "/hold_iters"}, 64'(bus.o_iterations), 64'(exp_k));
        end
        bus.i_start = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        exp_sched++;
        exp_matches += $countones(exp_m);
        check({tag, "/post_valid"}, 64'(bus.o_valid), 64'(0));
        check({tag, "/post_busy"}, 64'(bus.o_busy), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:N-1][0:M-1] om, rq;
        int ok, cyc;

        bus.i_start  = 1'b0; bus.i_ready  = 1'b0; bus.i_request  = '0;
        bus4.i_start = 1'b0; bus4.i_ready = 1'b0; bus4.i_request = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Reset state.
        check("rst/busy",  64'(bus.o_busy), 64'(0));
        check("rst/valid", 64'(bus.o_valid), 64'(0));
        check("rst/match", 64'(bus.o_match), 64'(0));
        check("rst/iters", 64'(bus.o_iterations), 64'(0));
        check("rst4/match", 64'(bus4.o_match), 64'(0));

        // ITERATIONS=4, all ones after reset: diagonal in four rounds.
        bus4.i_request = '1;
        bus4.i_start   = 1'b1;
        @(posedge clk); #1;
        bus4.i_start = 1'b0;
        cyc = 0;
        while (!bus4.o_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("it4/latency", 64'(cyc), 64'(4));
        check("it4/match", 64'(bus4.o_match), 64'(16'h8421));
        check("it4/iters", 64'(bus4.o_iterations), 64'(4));
        bus4.i_ready = 1'b1;
        @(posedge clk); #1;
        bus4.i_ready = 1'b0;
        check("it4/post_busy", 64'(bus4.o_busy), 64'(0));

        // Default build, all ones twice.
        run_sched('1, 0, "ones1", om, ok);
        check("ones1/diag", 64'(om), 64'(16'h8420));
        check("ones1/k", 64'(ok), 64'(3));
        run_sched('1, 0, "ones2", om, ok);

        // Empty request matrix.
        run_sched('0, 0, "empty", om, ok);
        check("empty/k", 64'(ok), 64'(1));
        check("empty/match0", 64'(om), 64'(0));

        // Permutation matched fully in round one.
        run_sched(16'h2814, 0, "perm", om, ok);
        check("perm/full", 64'(om), 64'(16'h2814));
        check("perm/k", 64'(ok), 64'(1));

        // Stall in DONE for five cycles with start pulses and request changes.
        run_sched(16'hB6D3, 5, "hold", om, ok);

        // Randomized schedules with random sparsity and stalls.
        for (int t = 0; t < 40; t++) begin
            rq = 16'($urandom);
            if ($urandom_range(0, 1) == 1) rq = rq & 16'($urandom);
            run_sched(rq, int'($urandom_range(0, 2)), "rand", om, ok);
        end

        // Reset while round 2 is pending.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        bus.i_request = '1;
        bus.i_start   = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(posedge clk); #1;
        check("mid/round1_done", 64'(bus.o_iterations), 64'(1));
        check("mid/busy_before", 64'(bus.o_busy), 64'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid/busy",  64'(bus.o_busy), 64'(0));
        check("mid/valid", 64'(bus.o_valid), 64'(0));
        check("mid/match", 64'(bus.o_match), 64'(0));
        run_sched('1, 0, "mid_ones", om, ok);
        check("mid_ones/diag", 64'(om), 64'(16'h8420));

        // Three handshakes since reset carrying 3, 0 and 4 matches.
        run_sched('0, 0, "st_empty", om, ok);
        run_sched(16'h2814, 0, "st_perm", om, ok);
`ifdef LIB_ISLIP_SCHED_STATS_EN
        check("stat/schedules", 64'(bus.o_stat_schedules), 64'(exp_sched));
        check("stat/matches", 64'(bus.o_stat_matches), 64'(exp_matches));
        check("stat/sched3", 64'(bus.o_stat_schedules), 64'(3));
        check("stat/match7", 64'(bus.o_stat_matches), 64'(7));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
